// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer of {pc, instr} entries; flush has priority over push.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem fetches, buffers words for decode.
// Optional FETCH_PERF_CNT_EN adds fetched/stalled performance counters.
module instruction_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               stall_d,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               valid_d,
  output logic [INSTR_W-1:0] instruction_d,
  output logic [XLEN-1:0]    pc_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   in_use;
  logic            fifo_empty;
  logic            req_fire;
  logic            rsp_fire;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign redirect_target = redirect_pc & ~32'h3;
  assign in_use          = outstanding + fifo_count;

  // Credit counts both in-flight and buffered words so a push never meets a full FIFO.
  assign imem_req_valid = rst_n && !redirect_valid && (in_use < CW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_fire   = imem_rsp_valid && (outstanding != '0);
  assign push       = rsp_fire && (discard == '0) && !redirect_valid;
  assign pop        = !fifo_empty && !stall_d;
  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC & ~32'h3;
      rsp_pc      <= RESET_PC & ~32'h3;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
        // Everything still in flight after this cycle belongs to the old path.
        discard  <= outstanding - CW'(rsp_fire);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_fire) begin
          if (discard != '0) discard <= discard - 1'b1;
          else               rsp_pc  <= rsp_pc + 32'd4;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign valid_d       = !fifo_empty;
  assign instruction_d = fifo_empty ? NOP_INSTR : head.instr;
  assign pc_d          = fifo_empty ? '0 : head.pc;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_cnt <= '0;
      perf_stall_cnt   <= '0;
    end else begin
      if (pop)                    perf_fetched_cnt <= perf_fetched_cnt + 32'd1;
      if (!fifo_empty && stall_d) perf_stall_cnt   <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized self-checking bench for instruction_fetch_unit against an epoch-tagged request/queue model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          FD  = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall_d;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        valid_d;
  logic [31:0] instruction_d;
  logic [31:0] pc_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  instruction_fetch_unit #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall_d        (stall_d),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .valid_d        (valid_d),
    .instruction_d  (instruction_d),
    .pc_d           (pc_d)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched_cnt (perf_fetched_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  req_t        pend[$];
  ent_t        bufq[$];
  logic [31:0] m_fetch;
  int          epoch;
  int          cyc;
  int          mem_lat;
  bit          jitter;
  int          checks;
  int          errors;
  int unsigned m_pops;
  int unsigned m_stalls;

  logic        obs_rv;
  logic        obs_vd;
  logic [31:0] obs_addr;
  logic [31:0] obs_pc;
  logic [31:0] obs_ins;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'h1357_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive memory response, compare outputs against the model, advance the model.
  task automatic step();
    bit   rv;
    bit   exp_rv;
    bit   exp_vd;
    int   lat;
    req_t r;
    ent_t e;
    @(negedge clk);
    rv = (pend.size() > 0) && (pend[0].due <= cyc) && (!jitter || ($urandom_range(3) != 0));
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? memw(pend[0].addr) : $urandom;
    #1;
    assert (!(imem_rsp_valid && pend.size() == 0)) else $error("response without outstanding request");
    exp_rv = !redirect_valid && ((pend.size() + bufq.size()) < FD);
    exp_vd = bufq.size() > 0;
    obs_rv = imem_req_valid; obs_vd = valid_d; obs_addr = imem_req_addr;
    obs_pc = pc_d;           obs_ins = instruction_d;
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
    if (exp_rv) chk("req_addr", imem_req_addr, m_fetch);
    chk("valid_d", {31'd0, valid_d}, {31'd0, exp_vd});
    if (exp_vd) begin
      chk("pc_d", pc_d, bufq[0].pc);
      chk("instruction_d", instruction_d, bufq[0].ins);
    end else begin
      chk("pc_d_idle", pc_d, 32'h0);
      chk("instr_idle", instruction_d, NOP);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched_cnt, m_pops);
    chk("perf_stall", perf_stall_cnt, m_stalls);
`endif
    @(posedge clk);
    if (exp_vd && !stall_d) m_pops++;
    if (exp_vd && stall_d)  m_stalls++;
    if (redirect_valid) begin
      bufq.delete();
      if (rv) r = pend.pop_front();
      epoch++;
      m_fetch = redirect_pc & ~32'h3;
    end else begin
      if (exp_vd && !stall_d) e = bufq.pop_front();
      if (rv) begin
        r = pend.pop_front();
        if (r.epoch == epoch) bufq.push_back('{pc: r.addr, ins: memw(r.addr)});
      end
      if (exp_rv && imem_req_ready) begin
        lat = (mem_lat > 0) ? mem_lat : int'($urandom_range(4, 1));
        pend.push_back('{addr: m_fetch, due: cyc + lat, epoch: epoch});
        m_fetch = m_fetch + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall_d = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(posedge clk);
    @(negedge clk); #1;
    chk("rst_valid_d", {31'd0, valid_d}, 32'd0);
    chk("rst_instr", instruction_d, NOP);
    chk("rst_pc_d", pc_d, 32'h0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched_cnt, 32'd0);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    pend.delete(); bufq.delete();
    m_fetch = RPC; epoch = 0; cyc = 0; m_pops = 0; m_stalls = 0;
    mem_lat = 1; jitter = 1'b0;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (obs_vd) begin
        seen = 1'b1;
        chk({name, "_pc"}, obs_pc, exp_pc);
        chk({name, "_ins"}, obs_ins, memw(exp_pc));
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no valid_d required=valid_d within 20 cycles", name);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;

    // Streaming from reset, 1-cycle memory.
    do_reset();
    step();
    chk("t1_addr0", obs_addr, 32'h100); chk("t1_rv0", {31'd0, obs_rv}, 32'd1);
    chk("t1_vd0", {31'd0, obs_vd}, 32'd0);
    step();
    chk("t1_addr1", obs_addr, 32'h104); chk("t1_vd1", {31'd0, obs_vd}, 32'd0);
    step();
    chk("t1_vd2", {31'd0, obs_vd}, 32'd1); chk("t1_pc2", obs_pc, 32'h100);
    chk("t1_ins2", obs_ins, 32'h1357_0100); chk("t1_rv2", {31'd0, obs_rv}, 32'd0);
    step();
    chk("t1_addr3", obs_addr, 32'h108); chk("t1_pc3", obs_pc, 32'h104);
    repeat (10) step();

    // Stall with a full buffer, then release.
    do_reset();
    stall_d = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_rv_stall", {31'd0, obs_rv}, 32'd0);
      chk("t2_pc_stall", obs_pc, 32'h100);
      chk("t2_ins_stall", obs_ins, 32'h1357_0100);
    end
    stall_d = 1'b0;
    step(); chk("t2_pc_rel0", obs_pc, 32'h100);
    step(); chk("t2_pc_rel1", obs_pc, 32'h104);
    repeat (10) step();

    // Redirect with two stale fetches in flight (latency 3).
    do_reset();
    mem_lat = 3;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    chk("t3_rv_redir", {31'd0, obs_rv}, 32'd0);
    redirect_valid = 1'b0;
    wait_valid("t3_first", 32'h200);
    repeat (8) step();

    // Redirect coinciding with stall and an arriving response; unaligned target.
    do_reset();
    stall_d = 1'b1;
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0;
    step();
    chk("t4_vd", {31'd0, obs_vd}, 32'd0);
    chk("t4_addr", obs_addr, 32'h200);
    chk("t4_rv", {31'd0, obs_rv}, 32'd1);
    stall_d = 1'b0;
    wait_valid("t4_first", 32'h200);

    // PC wrap at the top of the address space.
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step(); chk("t5_addr_top", obs_addr, 32'hFFFF_FFFC);
    step(); chk("t5_addr_wrap", obs_addr, 32'h0000_0000);
    repeat (10) step();

    // Randomized traffic: variable latency, backpressure, stalls, redirects.
    do_reset();
    mem_lat = 0; jitter = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      stall_d        = ($urandom_range(99) < 30);
      imem_req_ready = ($urandom_range(99) < 75);
      redirect_valid = ($urandom_range(99) < 3);
      redirect_pc    = $urandom;
      step();
    end
    redirect_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
